// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if
// Bundles the frame handshake (start/tx_data/busy/done/rx_data/parity_err)
// and the four SPI wires for spi_master_ctrl. The controller connects through
// the master modport; whatever drives requests and models the slave uses the
// slave modport.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              parity_err;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, parity_err, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, parity_err, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// SPI mode-0 master: one frame of DATA_W bits per accepted start, MSB first,
// SCLK half-period of HALF_PERIOD clk cycles. The FSM walks
// IDLE -> SETUP -> SHIFT -> DONE -> IDLE; all pin and handshake outputs are
// registers written by that FSM.
// Optional feature: define SPI_PARITY_EN to append an odd-parity bit to each
// transmitted frame and check the odd parity of the received frame. Without
// it, frames are DATA_W bits and parity_err is tied low.
module spi_master_ctrl #(
  parameter int DATA_W      = 8,
  parameter int HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_ctrl_if.master bus
);

`ifdef SPI_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BIT_W = $clog2(FRAME_LEN);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t               state_q;
  logic [HP_W-1:0]      hp_cnt_q;    // clk cycles within the current half-period
  logic [BIT_W-1:0]     bit_cnt_q;   // index of the next rising SCLK edge
  logic                 last_q;      // last bit has been sampled
  logic [FRAME_LEN-1:0] tx_shift_q;  // MSB drives mosi; cleared outside a frame
  logic [FRAME_LEN-1:0] rx_shift_q;
  logic                 sclk_q;
  logic                 cs_n_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DATA_W-1:0]    rx_data_q;
  logic [FRAME_LEN-1:0] tx_load_d;
  logic                 hp_tick_d;
`ifdef SPI_PARITY_EN
  logic                 perr_q;
  logic                 perr_d;
`endif

  // Frame image captured on an accepted start, plus the half-period tick
  always_comb begin
`ifdef SPI_PARITY_EN
    // Odd parity: the parity bit makes the total count of ones odd
    tx_load_d = {bus.tx_data, ~^bus.tx_data};
    // Received data+parity must hold an odd number of ones
    perr_d    = ~^rx_shift_q;
`else
    tx_load_d = bus.tx_data;
`endif
    hp_tick_d = (hp_cnt_q == HP_LAST);
  end

  // Frame sequencer; owns every registered output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hp_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
`ifdef SPI_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          cs_n_q <= 1'b1;
          sclk_q <= 1'b0;
          if (bus.start) begin
            // tx_data is copied here, so later changes cannot disturb the frame
            state_q    <= SETUP;
            busy_q     <= 1'b1;
            cs_n_q     <= 1'b0;
            tx_shift_q <= tx_load_d;
            hp_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
          end
        end

        SETUP: begin
          // cs_n low and MSB on mosi for one half-period before SCLK moves
          if (hp_tick_d) begin
            state_q  <= SHIFT;
            hp_cnt_q <= '0;
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end

        SHIFT: begin
          if (!hp_tick_d) begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end else begin
            hp_cnt_q <= '0;
            if (!sclk_q) begin
              // Rising edge: sample miso, which the slave set up while SCLK was low
              sclk_q     <= 1'b1;
              rx_shift_q <= {rx_shift_q[FRAME_LEN-2:0], bus.miso};
              if (bit_cnt_q == BIT_LAST) begin
                last_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              // Falling edge: either close the frame or present the next bit
              sclk_q <= 1'b0;
              if (last_q) begin
                state_q    <= DONE;
                cs_n_q     <= 1'b1;
                done_q     <= 1'b1;
                tx_shift_q <= '0;
                rx_data_q  <= rx_shift_q[FRAME_LEN-1 -: DATA_W];
`ifdef SPI_PARITY_EN
                perr_q     <= perr_d;
`endif
              end else begin
                tx_shift_q <= tx_shift_q << 1;
              end
            end
          end
        end

        DONE: begin
          // Leave unconditionally; a start seen here is dropped, not queued
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = tx_shift_q[FRAME_LEN-1];
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
`ifdef SPI_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// Scoreboard bench for spi_master_ctrl: each issued frame pushes its expected
// mosi bit stream, rx_data and parity_err; a negedge monitor pops an entry on
// every done pulse and also checks SCLK phase timing and done latency.
// Honours SPI_PARITY_EN the same way as the design.
module tb_spi_master_ctrl;
  localparam int DW = 8;
  localparam int HP = 2;
`ifdef SPI_PARITY_EN
  localparam int FL  = DW + 1;
  localparam int LAT = 39;
`else
  localparam int FL  = DW;
  localparam int LAT = 35;
`endif

  typedef struct {
    logic [FL-1:0] mosi;
    logic [DW-1:0] rx;
    logic          perr;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_W(DW)) bus ();

  spi_master_ctrl #(.DATA_W(DW), .HALF_PERIOD(HP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  sb_t sb_q[$];
  logic [FL-1:0] slave_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [FL-1:0] mosi_img(input logic [DW-1:0] tx);
`ifdef SPI_PARITY_EN
    return {tx, ~^tx};
`else
    return tx;
`endif
  endfunction

  function automatic logic [FL-1:0] slave_img(input logic [DW-1:0] rx, input logic pb);
`ifdef SPI_PARITY_EN
    return {rx, pb};
`else
    if (pb === 1'bx) return '0;
    return rx;
`endif
  endfunction

  function automatic logic perr_exp(input logic [DW-1:0] rx, input logic pb);
`ifdef SPI_PARITY_EN
    return ~^{rx, pb};
`else
    if (rx === 'x || pb === 1'bx) return 1'b1;
    return 1'b0;
`endif
  endfunction

  // Slave model: MSB on miso after cs_n falls, next bit after each SCLK fall
  logic [FL-1:0] s_shift;
  logic          s_prev_cs;
  logic          s_prev_sclk;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s_shift     <= '0;
      s_prev_cs   <= 1'b1;
      s_prev_sclk <= 1'b0;
      bus.miso    <= 1'b0;
    end else begin
      s_prev_cs   <= bus.cs_n;
      s_prev_sclk <= bus.sclk;
      if (s_prev_cs && !bus.cs_n) begin
        bus.miso <= slave_word[FL-1];
        s_shift  <= slave_word << 1;
      end else if (s_prev_sclk && !bus.sclk && !bus.cs_n) begin
        bus.miso <= s_shift[FL-1];
        s_shift  <= s_shift << 1;
      end
    end
  end

  // Monitor: sample away from the active edge, pop the scoreboard on done
  int cyc = 0;
  int accept_cyc = 0;
  int last_rise = 0;
  int last_fall = 0;
  int rises = 0;
  int n_done = 0;
  int prev_done_cyc = -1;
  int done_gap = 0;
  int idle_run = 0;
  int last_idle_run = 0;
  logic first_rise = 1'b1;
  logic prev_busy = 1'b0;
  logic prev_sclk = 1'b0;
  logic [FL-1:0] mosi_acc = '0;
  sb_t exp_e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_busy     = 1'b0;
      prev_sclk     = 1'b0;
      rises         = 0;
      first_rise    = 1'b1;
      prev_done_cyc = -1;
      idle_run      = 0;
    end else begin
      check("sclk_low_when_deselected", {31'd0, bus.cs_n & bus.sclk}, 32'd0);
      if (bus.busy && !prev_busy) begin
        accept_cyc    = cyc;
        rises         = 0;
        mosi_acc      = '0;
        first_rise    = 1'b1;
        last_idle_run = idle_run;
        idle_run      = 0;
        check("cs_n_low_with_busy", {31'd0, bus.cs_n}, 32'd0);
      end
      if (bus.cs_n && !bus.done) idle_run++;
      if (bus.sclk && !prev_sclk) begin
        rises++;
        mosi_acc = {mosi_acc[FL-2:0], bus.mosi};
        if (first_rise) check("first_rise_after_cs", cyc - accept_cyc, 32'd4);
        else            check("sclk_low_phase", cyc - last_fall, HP);
        first_rise = 1'b0;
        last_rise  = cyc;
      end
      if (!bus.sclk && prev_sclk) begin
        check("sclk_high_phase", cyc - last_rise, HP);
        last_fall = cyc;
      end
      if (bus.done) begin
        n_done++;
        check("done_pins_cs_sclk_mosi", {29'd0, bus.cs_n, bus.sclk, bus.mosi}, 32'd4);
        if (prev_done_cyc >= 0) done_gap = cyc - prev_done_cyc;
        prev_done_cyc = cyc;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got a done pulse, expected none (t=%0t)", $time);
        end else begin
          exp_e = sb_q.pop_front();
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_e.rx});
          check("parity_err", {31'd0, bus.parity_err}, {31'd0, exp_e.perr});
          check("mosi_stream", 32'(mosi_acc), 32'(exp_e.mosi));
          check("sclk_rise_count", rises, FL);
          check("done_latency", cyc - accept_cyc + 1, LAT);
          $display("done #%0d: mosi=0x%0h rx_data=0x%0h parity_err=%0b latency=%0d",
                   n_done, mosi_acc, bus.rx_data, bus.parity_err, cyc - accept_cyc + 1);
        end
      end
      prev_busy = bus.busy;
      prev_sclk = bus.sclk;
    end
  end

  task automatic wait_done(input int target);
    for (int i = 0; i < 200 && n_done < target; i++) @(negedge clk);
    check("done_within_budget", {31'd0, n_done >= target}, 32'd1);
  endtask

  task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] rx, input logic pb);
    int base;
    base = n_done;
    slave_word = slave_img(rx, pb);
    sb_q.push_back('{mosi: mosi_img(tx), rx: rx, perr: perr_exp(rx, pb)});
    bus.tx_data = tx;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.tx_data = ~tx;
    wait_done(base + 1);
    repeat (3) @(negedge clk);
    check("rx_data_held", {24'd0, bus.rx_data}, {24'd0, rx});
    $display("frame tx=0x%0h slave=0x%0h issued", tx, slave_word);
  endtask

  logic [DW-1:0] tbl_tx [4] = '{8'hA5, 8'h00, 8'hFF, 8'h03};
  logic [DW-1:0] tbl_rx [4] = '{8'h3C, 8'hFF, 8'h00, 8'h01};
  logic          tbl_pb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int base;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    check("rst_sclk", {31'd0, bus.sclk}, 32'd0);
    check("rst_mosi", {31'd0, bus.mosi}, 32'd0);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_release", {30'd0, bus.cs_n, bus.busy}, 32'd2);

    // Directed frames, including A5/3C and the 03/01+parity1 case
    for (int i = 0; i < 4; i++) run_frame(tbl_tx[i], tbl_rx[i], tbl_pb[i]);

    // A second start while busy (tx_data=FF) is ignored: one A5 frame, one done
    base = n_done;
    slave_word = slave_img(8'h3C, 1'b1);
    sb_q.push_back('{mosi: mosi_img(8'hA5), rx: 8'h3C, perr: perr_exp(8'h3C, 1'b1)});
    bus.tx_data = 8'hA5;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(base + 1);
    repeat (50) @(negedge clk);
    check("single_done_when_ignored", n_done, base + 1);
    $display("ignore-while-busy transaction complete");

    // Back-to-back: start held high across two frames
    base = n_done;
    slave_word = slave_img(8'h3C, 1'b1);
    sb_q.push_back('{mosi: mosi_img(8'hA5), rx: 8'h3C, perr: perr_exp(8'h3C, 1'b1)});
    sb_q.push_back('{mosi: mosi_img(8'h5A), rx: 8'h3C, perr: perr_exp(8'h3C, 1'b1)});
    bus.tx_data = 8'hA5;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.tx_data = 8'h5A;
    wait_done(base + 1);
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(base + 2);
    check("idle_cycles_between_frames", last_idle_run, 32'd1);
    check("done_to_done_spacing", done_gap, LAT + 1);
    repeat (5) @(negedge clk);
    $display("back-to-back transaction complete");

    // Reset in the middle of SHIFT aborts the frame with no done
    base = n_done;
    slave_word = slave_img(8'h96, 1'b0);
    bus.tx_data = 8'hC3;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_frame_selected", {31'd0, bus.cs_n}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    check("midrst_sclk", {31'd0, bus.sclk}, 32'd0);
    check("midrst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("midrst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("midrst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("no_done_after_reset", n_done, base);
    check("stays_idle_after_reset", {31'd0, bus.cs_n}, 32'd1);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("mid-frame reset transaction complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
